uart_loader: RTL and testbench
==============================

Name: uart_loader

Overview:
- Boot loader that sits directly upstream of the core's program memory.
- Receives a framed program image over a UART RX line and writes 32-bit words into the memory write port.
- Holds the core stopped (core_run=0) until a complete, checksum-valid image has been written, then releases it.
- Contains a byte-level UART receiver plus a frame-parsing FSM.

Parameters:
- CLK_DIV, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4.
- ADDR_W, 12, memory word-address width; maximum image = 2**ADDR_W words.
- DATA_W, 32, memory word width; fixed at 32 (4 bytes/word).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx  in  1  UART line, idle high, 8N1, LSB first, asynchronous to clk
- mem_addr  out  ADDR_W  word address for memory write port
- mem_data  out  DATA_W  word to write
- mem_we  out  1  one-cycle write strobe
- core_run  out  1  1 = core may execute; 0 = core held in FETCH at PC 0
- busy  out  1  frame in progress (any state other than IDLE/RUN)
- frame_err  out  1  sticky: stop-bit error, bad count or checksum mismatch; cleared by the next valid header
- load_done  out  1  one-cycle pulse when the image is accepted

Behaviour:
- Reset values: mem_addr=0, mem_data=0, mem_we=0, core_run=0, busy=0, frame_err=0, load_done=0.
  - RX state returns to idle; any partial frame is discarded.
- RX synchroniser: rx passes through a 2-FF synchroniser before use.
- RX start detection: a high->low transition of the synchronised rx starts a byte. The line is re-sampled after CLK_DIV/2 cycles (integer divide).
  - If the line is high again, it was a glitch: return to RX idle and emit no byte.
- RX data and stop bits: then 8 data bits are sampled at CLK_DIV intervals, followed by the stop bit.
  - Stop bit = 1: byte_valid pulses for 1 cycle with byte_data.
  - Stop bit = 0: byte_err pulses and no byte is emitted. RX then waits for the line to go high before hunting for the next start bit.
- Frame format: 0xA5, CNT_LO, CNT_HI, then CNT*4 payload bytes (each word little-endian), then CHK.
  - CHK = XOR of all payload bytes. CNT bytes and header are not included in CHK.
- Loader FSM states: IDLE, CNT0, CNT1, DATA, CHK, RUN.
- IDLE:
  - Byte 0xA5 -> CNT0, clear frame_err, clear running XOR.
  - Any other byte is ignored.
- CNT0 -> CNT1: latches CNT_LO.
- CNT1: latches CNT_HI, then dispatches on CNT:
  - CNT == 0 -> CHK.
  - CNT > 2**ADDR_W -> set frame_err, go to IDLE.
  - Otherwise -> DATA with word index 0 and byte index 0.
- DATA: each byte is shifted into the word at byte position byte_idx (byte 0 = bits 7:0) and XORed into the checksum.
  - On the 4th byte, on the next clk: mem_we=1, mem_addr=word index, mem_data=assembled word.
  - The word index then increments. After word CNT-1 is written -> CHK.
  - mem_addr/mem_data hold their last values while mem_we=0.
- CHK: byte == running XOR -> RUN, core_run=1 and load_done pulses on the next clk. Mismatch -> frame_err=1, IDLE, core_run stays 0.
- RUN: core_run stays 1 and busy=0.
  - Byte 0xA5 -> core_run=0 on the next clk, then continue as from IDLE (reload).
  - Any other byte is ignored.
- byte_err while in CNT0/CNT1/DATA/CHK: frame_err=1, go to IDLE, words already written remain in memory, core_run=0.
  - byte_err in IDLE/RUN is ignored.
- Word index never wraps: the count check bounds it to 2**ADDR_W-1. A CNT of exactly 2**ADDR_W is legal and fills the whole memory.
- core_run is never 1 while mem_we can pulse; the core must not fetch during a load.
- busy = 1 in CNT0, CNT1, DATA, CHK.

Decomposition:
- Package uart_loader_pkg:
  - loader state enum (IDLE..RUN);
  - localparam HDR_BYTE = 8'hA5;
  - localparam BYTES_PER_WORD = 4.
- Sub-module uart_rx_byte (params CLK_DIV):
  - ports clk, rst_n, rx, byte_valid, byte_data[7:0], byte_err;
  - owns the synchroniser, bit counter and baud counter.
- The top level holds the frame FSM, word assembly, checksum and outputs.

Test Plan:
- CLK_DIV=8; send A5 02 00 | 13 00 00 00 | 01 00 00 01 | CHK=0x13 -> mem_we pulses at addr 0 data 0x00000013, then at addr 1 data 0x01000001; load_done pulses once, core_run=1, frame_err=0.
- Same frame with CHK=0x00 -> both writes occur, core_run stays 0, frame_err=1, FSM back in IDLE; then a valid frame -> frame_err cleared, core_run=1.
- Frame with stop bit forced 0 on the 3rd payload byte -> frame_err=1, no mem_we for word 0, core_run=0, busy=0.
- A5 01 10 (CNT=0x1001 > 4096) -> frame_err=1, no mem_we; A5 00 00 CHK=00 -> core_run=1, load_done, no writes.
- While core_run=1, send A5 01 00 + word 0xDEADBEEF (EF BE AD DE) + CHK 0x22 -> core_run drops the cycle after the header, write at addr 0 data 0xDEADBEEF, then core_run=1 again.
- Drive rst_n=0 for 1 cycle mid-DATA -> all outputs return to reset values, partial word dropped; a 3-cycle low glitch on rx (< CLK_DIV/2) -> no byte_valid, no state change.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Loader frame states, RX byte states and frame constants.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT0,
      S_CNT1,
      S_DATA,
      S_CHK,
      S_RUN
   } ld_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT
   } rx_state_t;

   localparam logic [7:0] HDR_BYTE = 8'hA5;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with input synchroniser.
// Emits one-cycle byte_valid or byte_err pulses per received frame.
module uart_rx_byte
   import uart_loader_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_err
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

   logic          s1;
   logic          s2;
   logic          s3;
   rx_state_t     st;
   logic [CW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1         <= 1'b1;
         s2         <= 1'b1;
         s3         <= 1'b1;
         st         <= RX_IDLE;
         baud       <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         byte_err   <= 1'b0;
      end else begin
         s1         <= rx;
         s2         <= s1;
         s3         <= s2;
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
         unique case (st)
            RX_IDLE: begin
               if (s3 && !s2) begin
                  st   <= RX_START;
                  baud <= HALF;
               end
            end
            RX_START: begin
               if (baud == '0) begin
                  // line back high at mid start bit: treat as glitch
                  if (s2) begin
                     st <= RX_IDLE;
                  end else begin
                     st      <= RX_DATA;
                     baud    <= FULL;
                     bit_idx <= '0;
                  end
               end else begin
                  baud <= baud - 1'b1;
               end
            end
            RX_DATA: begin
               if (baud == '0) begin
                  shift   <= {s2, shift[7:1]};
                  baud    <= FULL;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     st <= RX_STOP;
                  end
               end else begin
                  baud <= baud - 1'b1;
               end
            end
            RX_STOP: begin
               if (baud == '0) begin
                  if (s2) begin
                     byte_valid <= 1'b1;
                     byte_data  <= shift;
                     st         <= RX_IDLE;
                  end else begin
                     byte_err <= 1'b1;
                     st       <= RX_WAIT;
                  end
               end else begin
                  baud <= baud - 1'b1;
               end
            end
            RX_WAIT: begin
               if (s2) begin
                  st <= RX_IDLE;
               end
            end
            default: st <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: parses A5/CNT/payload/CHK frames into memory
// writes and releases the core once a checksum-valid image lands.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int CLK_DIV = 434,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_we,
   output logic              core_run,
   output logic              busy,
   output logic              frame_err,
   output logic              load_done
);

   localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_err;

   ld_state_t         state;
   logic [7:0]        cnt_lo;
   logic [15:0]       cnt_full;
   logic [ADDR_W-1:0] word_idx;
   logic [ADDR_W-1:0] last_idx;
   logic [1:0]        byte_idx;
   logic [DATA_W-1:0] word;
   logic [DATA_W-1:0] nxt_word;
   logic [7:0]        csum;

   uart_rx_byte #(
      .CLK_DIV (CLK_DIV)
   ) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .byte_valid (rx_valid),
      .byte_data  (rx_data),
      .byte_err   (rx_err)
   );

   assign cnt_full = {rx_data, cnt_lo};

   assign busy = (state == S_CNT0) || (state == S_CNT1)
              || (state == S_DATA) || (state == S_CHK);

   always_comb begin
      nxt_word = word;
      nxt_word[8*byte_idx +: 8] = rx_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt_lo    <= '0;
         word_idx  <= '0;
         last_idx  <= '0;
         byte_idx  <= '0;
         word      <= '0;
         csum      <= '0;
         mem_addr  <= '0;
         mem_data  <= '0;
         mem_we    <= 1'b0;
         core_run  <= 1'b0;
         frame_err <= 1'b0;
         load_done <= 1'b0;
      end else begin
         mem_we    <= 1'b0;
         load_done <= 1'b0;
         if (rx_err && busy) begin
            frame_err <= 1'b1;
            core_run  <= 1'b0;
            state     <= S_IDLE;
         end else if (rx_valid) begin
            unique case (state)
               S_IDLE, S_RUN: begin
                  if (rx_data == HDR_BYTE) begin
                     state     <= S_CNT0;
                     frame_err <= 1'b0;
                     csum      <= '0;
                     core_run  <= 1'b0;
                  end
               end
               S_CNT0: begin
                  cnt_lo <= rx_data;
                  state  <= S_CNT1;
               end
               S_CNT1: begin
                  if (cnt_full == '0) begin
                     state <= S_CHK;
                  end else if ({1'b0, cnt_full} > MAX_WORDS) begin
                     frame_err <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     state    <= S_DATA;
                     word_idx <= '0;
                     byte_idx <= '0;
                     // count is bounded above, so count-1 fits the index
                     last_idx <= ADDR_W'(cnt_full - 16'd1);
                  end
               end
               S_DATA: begin
                  word     <= nxt_word;
                  csum     <= csum ^ rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'(BYTES_PER_WORD - 1)) begin
                     mem_we   <= 1'b1;
                     mem_addr <= word_idx;
                     mem_data <= nxt_word;
                     if (word_idx == last_idx) begin
                        state <= S_CHK;
                     end else begin
                        word_idx <= word_idx + 1'b1;
                     end
                  end
               end
               S_CHK: begin
                  if (rx_data == csum) begin
                     state     <= S_RUN;
                     core_run  <= 1'b1;
                     load_done <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Randomised scoreboard bench for uart_loader with a frame-level model.
module tb_uart_loader;

   localparam int CLK_DIV = 8;
   localparam int ADDR_W  = 12;
   localparam int GAP     = 4;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   typedef logic [7:0] bq_t[$];

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx = 1'b1;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;
   logic              mem_we;
   logic              core_run;
   logic              busy;
   logic              frame_err;
   logic              load_done;

   int  compared = 0;
   int  mismatched = 0;
   int  done_seen = 0;
   int  exp_done = 0;
   bit  exp_run = 0;
   bit  exp_err = 0;
   wr_t exp_q[$];
   wr_t e;

   uart_loader #(
      .CLK_DIV (CLK_DIV),
      .ADDR_W  (ADDR_W),
      .DATA_W  (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_we    (mem_we),
      .core_run  (core_run),
      .busy      (busy),
      .frame_err (frame_err),
      .load_done (load_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every write must match the next expected one
   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         check("run_during_we", 32'(core_run), 32'd0);
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_write addr=%0h data=%0h required=none",
                     mem_addr, mem_data);
         end else begin
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_data !== e.data) begin
               mismatched++;
               $display("FAIL write addr=%0h data=%0h required addr=%0h data=%0h",
                        mem_addr, mem_data, e.addr, e.data);
            end
         end
      end
      if (rst_n && load_done) done_seen++;
   end

   // Frame-level reference: bytes before 'bad' are delivered, 'bad' has a
   // broken stop bit and nothing after it is sent.
   task automatic model_frame(input bq_t f, input int bad);
      int n;
      int cnt;
      int nw;
      logic [7:0] x;
      wr_t w;
      n = (bad >= 0) ? bad : f.size();
      exp_run = 0;
      exp_err = 0;
      if (n < 3) begin
         exp_err = 1;
         return;
      end
      cnt = int'(f[1]) + 256 * int'(f[2]);
      if (cnt > (1 << ADDR_W)) begin
         exp_err = 1;
         return;
      end
      nw = (n - 3) / 4;
      if (nw > cnt) nw = cnt;
      for (int k = 0; k < nw; k++) begin
         w.addr = ADDR_W'(k);
         w.data = {f[6+4*k], f[5+4*k], f[4+4*k], f[3+4*k]};
         exp_q.push_back(w);
      end
      if (n < 4 * cnt + 4) begin
         exp_err = 1;
         return;
      end
      x = 8'h00;
      for (int i = 0; i < 4 * cnt; i++) x ^= f[3+i];
      if (f[3+4*cnt] == x) begin
         exp_run = 1;
         exp_done++;
      end else begin
         exp_err = 1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad);
      @(negedge clk);
      rx = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      rx = !bad;
      repeat (CLK_DIV) @(negedge clk);
      rx = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic send_frame(input bq_t f, input int bad);
      model_frame(f, bad);
      for (int i = 0; i < f.size(); i++) begin
         if (i == bad) begin
            send_byte(f[i], 1'b1);
            break;
         end
         send_byte(f[i], 1'b0);
      end
   endtask

   task automatic checkpoint(input string tag);
      repeat (30) @(negedge clk);
      check({tag, "_core_run"}, 32'(core_run), 32'(exp_run));
      check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_err));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_load_done_count"}, 32'(done_seen), 32'(exp_done));
      exp_q.delete();
   endtask

   initial begin
      bq_t f;
      bq_t good;
      int  cnt;
      int  bad;
      logic [7:0] x;

      repeat (3) @(negedge clk);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_data", mem_data, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_core_run", 32'(core_run), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      good = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h00, 8'h00, 8'h01, 8'h13};
      send_frame(good, -1);
      checkpoint("basic");

      f = good;
      f[11] = 8'h00;
      send_frame(f, -1);
      checkpoint("bad_chk");
      send_frame(good, -1);
      checkpoint("recover");

      send_frame(good, 5);
      checkpoint("stop_err");

      f = '{8'hA5, 8'h01, 8'h10};
      send_frame(f, -1);
      checkpoint("cnt_over");
      f = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_frame(f, -1);
      checkpoint("cnt_zero");

      f = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      model_frame(f, -1);
      send_byte(f[0], 1'b0);
      check("reload_core_run_drop", 32'(core_run), 32'd0);
      check("reload_busy", 32'(busy), 32'd1);
      for (int i = 1; i < f.size(); i++) send_byte(f[i], 1'b0);
      checkpoint("reload");

      f = '{8'hA5, 8'h00, 8'h10, 8'h55};
      model_frame(f, 3);
      for (int i = 0; i < 3; i++) send_byte(f[i], 1'b0);
      check("cnt_max_busy", 32'(busy), 32'd1);
      check("cnt_max_frame_err", 32'(frame_err), 32'd0);
      send_byte(f[3], 1'b1);
      checkpoint("cnt_max");

      exp_q.push_back('{ADDR_W'(0), 32'h00000013});
      for (int i = 0; i < 9; i++) send_byte(good[i], 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
      check("mid_rst_mem_data", mem_data, 32'd0);
      check("mid_rst_core_run", 32'(core_run), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_frame_err", 32'(frame_err), 32'd0);
      exp_run = 0;
      exp_err = 0;
      checkpoint("mid_rst");

      f = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      model_frame(f, -1);
      for (int i = 0; i < 3; i++) send_byte(f[i], 1'b0);
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CLK_DIV) @(negedge clk);
      check("glitch_busy", 32'(busy), 32'd1);
      for (int i = 3; i < f.size(); i++) send_byte(f[i], 1'b0);
      checkpoint("glitch");

      for (int r = 0; r < 8; r++) begin
         cnt = $urandom_range(0, 3);
         f = '{8'hA5, 8'(cnt), 8'h00};
         x = 8'h00;
         for (int i = 0; i < 4 * cnt; i++) begin
            f.push_back(8'($urandom));
            x ^= f[f.size()-1];
         end
         if ($urandom_range(0, 2) == 0) x ^= 8'($urandom_range(1, 255));
         f.push_back(x);
         bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, f.size() - 1) : -1;
         send_frame(f, bad);
         checkpoint("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
